mul8u_mac_stage: RTL and testbench

Pipelined multiply-accumulate stage that sits directly downstream of the 8x8 unsigned approximate multipliers (mul8u_* family). It registers operand pairs and drives them into an externally instantiated combinational multiplier. It captures the 16-bit product and accumulates products over a frame delimited by a last flag. It presents the frame sum through a valid/ready output, so any approximate multiplier variant can be evaluated under a realistic dot-product workload.

---
 rtl/mul8u_mac_stage.sv | 103 ++++++++++
 tb/tb_mul8u_mac_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul8u_mac_stage.sv
// Three-stage multiply-accumulate wrapper around an external combinational 8x8 multiplier.
// Sums products over a frame delimited by in_last and holds the result behind a valid/ready port.
module mul8u_mac_stage #(
    parameter int ACC_W = 24,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             out_sat
);

    logic             r_s1_valid, r_s1_last;
    logic [7:0]       r_mul_a, r_mul_b;
    logic             r_s2_valid, r_s2_last;
    logic [15:0]      r_s2_p;
    logic [ACC_W-1:0] r_acc, r_out_acc;
    logic [7:0]       r_cnt, r_out_count;
    logic             r_sat, r_out_sat, r_out_valid;

    logic             w_stall, w_adv, w_ovf, w_sat_nxt;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [7:0]       w_cnt_nxt;

    // Only a finished frame about to overwrite an unconsumed result freezes the pipe.
    assign w_stall   = r_out_valid & ~out_ready & r_s2_valid & r_s2_last;
    assign w_adv     = ~w_stall;

    assign w_sum     = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, r_s2_p};
    assign w_ovf     = w_sum[ACC_W];
    assign w_acc_nxt = (SAT != 0 && w_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_cnt_nxt = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    assign w_sat_nxt = r_sat | w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_p      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_last <= in_last;
                r_mul_a   <= in_a;
                r_mul_b   <= in_b;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_p     <= mul_o;

            if (r_s2_valid && !r_s2_last) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                r_sat <= w_sat_nxt;
            end

            // Frame close: publish the sum and restart the accumulator on the same edge.
            if (r_s2_valid && r_s2_last) begin
                r_out_acc   <= w_acc_nxt;
                r_out_count <= w_cnt_nxt;
                r_out_sat   <= w_sat_nxt;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_sat       <= 1'b0;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_adv;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_mul8u_mac_stage.sv
// Directed bench: three stage instances (24-bit sat, 16-bit sat, 16-bit wrap) share one
// stimulus stream, each fed by an exact-product multiplier model.
module tb_mul8u_mac_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [7:0]  in_a, in_b;

    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, os0, os1, os2;
    logic [7:0]  ma0, mb0, ma1, mb1, ma2, mb2, oc0, oc1, oc2;
    logic [15:0] p0, p1, p2, oa1, oa2;
    logic [23:0] oa0;

    assign p0 = {8'd0, ma0} * {8'd0, mb0};
    assign p1 = {8'd0, ma1} * {8'd0, mb1};
    assign p2 = {8'd0, ma2} * {8'd0, mb2};

    always #5 clk = ~clk;

    mul8u_mac_stage #(.ACC_W(24), .SAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma0), .mul_b(mb0),
        .mul_o(p0), .out_valid(ov0), .out_ready(out_ready), .out_acc(oa0),
        .out_count(oc0), .out_sat(os0));

    mul8u_mac_stage #(.ACC_W(16), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma1), .mul_b(mb1),
        .mul_o(p1), .out_valid(ov1), .out_ready(out_ready), .out_acc(oa1),
        .out_count(oc1), .out_sat(os1));

    mul8u_mac_stage #(.ACC_W(16), .SAT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma2), .mul_b(mb2),
        .mul_o(p2), .out_valid(ov2), .out_ready(out_ready), .out_acc(oa2),
        .out_count(oc2), .out_sat(os2));

    typedef struct {
        logic [31:0] acc;
        logic [7:0]  cnt;
        logic        sat;
        int          cyc;
    } res_t;

    res_t q0[$], q1[$], q2[$];
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;

    // Record every accepted result; inputs only move just after posedge, so negedge sees the handshake.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ov0 && out_ready) q0.push_back('{32'(oa0), oc0, os0, cyc});
        if (ov1 && out_ready) q1.push_back('{32'(oa1), oc1, os1, cyc});
        if (ov2 && out_ready) q2.push_back('{32'(oa2), oc2, os2, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int waited = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        @(negedge clk);
        while (!rdy0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, ov0}, 0);
        chk("rst_out_acc", 32'(oa0), 0);
        chk("rst_in_ready", {31'd0, rdy0}, 1);
        chk("rst_mul_a", {24'd0, ma0}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Basic frame and latency: pulse appears after edge t+2 only.
        q0.delete();
        send(3, 5, 0); send(10, 20, 0); send(255, 255, 1);
        @(negedge clk); chk("lat_t0", {31'd0, ov0}, 0);
        @(negedge clk); chk("lat_t1", {31'd0, ov0}, 0);
        @(negedge clk); chk("lat_t2", {31'd0, ov0}, 1);
        chk("f1_acc", 32'(oa0), 65240);
        chk("f1_cnt", {24'd0, oc0}, 3);
        chk("f1_sat", {31'd0, os0}, 0);
        @(negedge clk); chk("f1_pulse_end", {31'd0, ov0}, 0);
        chk("f1_npulse", q0.size(), 1);
        chk("mul_a_hold", {24'd0, ma0}, 255);
        idle(2);

        // Back-to-back single-element frames.
        q0.delete();
        send(2, 2, 1); send(7, 9, 1);
        idle(6);
        chk("b2b_n", q0.size(), 2);
        if (q0.size() == 2) begin
            chk("b2b_acc0", q0[0].acc, 4);
            chk("b2b_acc1", q0[1].acc, 63);
            chk("b2b_adjacent", q0[1].cyc - q0[0].cyc, 1);
        end

        // Backpressure: second frame parks in S2 and stalls the input.
        q0.delete();
        out_ready = 1'b0;
        send(1, 1, 1); send(2, 3, 1);
        @(negedge clk); chk("bp_ready_before", {31'd0, rdy0}, 1);
        @(negedge clk); chk("bp_ready_drop", {31'd0, rdy0}, 0);
        chk("bp_valid", {31'd0, ov0}, 1);
        repeat (8) @(negedge clk);
        chk("bp_acc_hold", 32'(oa0), 1);
        chk("bp_cnt_hold", {24'd0, oc0}, 1);
        chk("bp_ready_held", {31'd0, rdy0}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(5);
        chk("bp_n", q0.size(), 2);
        if (q0.size() == 2) begin
            chk("bp_acc0", q0[0].acc, 1);
            chk("bp_acc1", q0[1].acc, 6);
        end
        chk("bp_ready_back", {31'd0, rdy0}, 1);

        // Overflow at 16 bits, then recovery on the next frame.
        q0.delete(); q1.delete(); q2.delete();
        send(255, 255, 0); send(255, 255, 1);
        idle(5);
        send(1, 1, 1);
        idle(5);
        chk("ovf_n_sat", q1.size(), 2);
        chk("ovf_n_wrap", q2.size(), 2);
        if (q1.size() == 2) begin
            chk("ovf_sat_acc", q1[0].acc, 65535);
            chk("ovf_sat_flag", {31'd0, q1[0].sat}, 1);
            chk("ovf_sat_cnt", {24'd0, q1[0].cnt}, 2);
            chk("rec_sat_acc", q1[1].acc, 1);
            chk("rec_sat_flag", {31'd0, q1[1].sat}, 0);
        end
        if (q2.size() == 2) begin
            chk("ovf_wrap_acc", q2[0].acc, 64514);
            chk("ovf_wrap_flag", {31'd0, q2[0].sat}, 1);
            chk("rec_wrap_acc", q2[1].acc, 1);
            chk("rec_wrap_flag", {31'd0, q2[1].sat}, 0);
        end
        if (q0.size() >= 1) begin
            chk("wide_acc", q0[0].acc, 130050);
            chk("wide_sat", {31'd0, q0[0].sat}, 0);
        end

        // Asynchronous reset mid-frame discards the partial sum.
        send(100, 100, 0); send(50, 50, 0);
        #3 rst_n = 1'b0;
        #2;
        chk("arst_out_valid", {31'd0, ov0}, 0);
        chk("arst_out_acc", 32'(oa0), 0);
        chk("arst_out_cnt", {24'd0, oc0}, 0);
        chk("arst_mul_a", {24'd0, ma0}, 0);
        chk("arst_in_ready", {31'd0, rdy0}, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q0.delete();
        send(4, 4, 1);
        idle(5);
        chk("arst_n", q0.size(), 1);
        if (q0.size() == 1) begin
            chk("arst_acc", q0[0].acc, 16);
            chk("arst_cnt", {24'd0, q0[0].cnt}, 1);
        end

        // Element count saturates at 255 while the sum keeps going.
        q0.delete();
        for (int i = 0; i < 300; i++) send(1, 1, (i == 299));
        idle(5);
        chk("cnt_n", q0.size(), 1);
        if (q0.size() == 1) begin
            chk("cnt_acc", q0[0].acc, 300);
            chk("cnt_cnt", {24'd0, q0[0].cnt}, 255);
            chk("cnt_sat", {31'd0, q0[0].sat}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
